// File: rtl/sync_fifo_if.sv
// Handshake/status bundle for sync_fifo; the user side drives through master, the FIFO uses slave.
// overflow/underflow are present only when SYNC_FIFO_ERR_EN is defined.
interface sync_fifo_if #(
    parameter int WIDTH    = 8,
    parameter int PTRWIDTH = 2
);
    logic                clear;
    logic                wr_en;
    logic [WIDTH-1:0]    data_in;
    logic                rd_en;
    logic [WIDTH-1:0]    data_out;
    logic                valid;
    logic [PTRWIDTH:0]   usedw;
    logic                empty;
    logic                full;
    logic                almost_empty;
    logic                almost_full;
`ifdef SYNC_FIFO_ERR_EN
    logic                overflow;
    logic                underflow;
`endif

    modport master (
        output clear, wr_en, data_in, rd_en,
        input  data_out, valid, usedw, empty, full, almost_empty, almost_full
`ifdef SYNC_FIFO_ERR_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  clear, wr_en, data_in, rd_en,
        output data_out, valid, usedw, empty, full, almost_empty, almost_full
`ifdef SYNC_FIFO_ERR_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, depth 2**PTRWIDTH, registered flags, standard or show-ahead (FWFT) read.
// Optional sticky overflow/underflow outputs when SYNC_FIFO_ERR_EN is defined.
module sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int PTRWIDTH = 2,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input logic        clk,
    input logic        rst_n,
    sync_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** PTRWIDTH;

    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("sync_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= 2**PTRWIDTH");
    end

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTRWIDTH:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, used_n;
    logic [PTRWIDTH:0] usedw_q;
    logic              empty_q, full_q, ae_q, af_q;
    logic              wr_acc, rd_acc, flush;
    logic [WIDTH-1:0]  dout;
    logic              vld;

    assign flush  = !rst_n || bus.clear;
    assign wr_acc = bus.wr_en && !full_q;
    assign rd_acc = bus.rd_en && !empty_q;

    always_comb begin
        wr_ptr_n = wr_ptr + {{PTRWIDTH{1'b0}}, wr_acc};
        rd_ptr_n = rd_ptr + {{PTRWIDTH{1'b0}}, rd_acc};
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end
        used_n = wr_ptr_n - rd_ptr_n;
    end

    // Flags are derived from the next pointers so they change on the accepting edge.
    always_ff @(posedge clk) begin
        wr_ptr  <= wr_ptr_n;
        rd_ptr  <= rd_ptr_n;
        usedw_q <= used_n;
        empty_q <= (wr_ptr_n == rd_ptr_n);
        full_q  <= (wr_ptr_n[PTRWIDTH-1:0] == rd_ptr_n[PTRWIDTH-1:0]) &&
                   (wr_ptr_n[PTRWIDTH] != rd_ptr_n[PTRWIDTH]);
        ae_q    <= (int'(used_n) <= AE_LEVEL);
        af_q    <= (int'(used_n) >= AF_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !flush)
            mem[wr_ptr[PTRWIDTH-1:0]] <= bus.data_in;
    end

    if (FWFT == 0) begin : g_std
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout <= '0;
                vld  <= 1'b0;
            end else if (bus.clear) begin
                vld  <= 1'b0;
            end else begin
                vld  <= rd_acc;
                if (rd_acc)
                    dout <= mem[rd_ptr[PTRWIDTH-1:0]];
            end
        end
    end else begin : g_fwft
        // Head word is shown directly; blanked while empty so nothing stale leaks out.
        assign vld  = !empty_q;
        assign dout = empty_q ? '0 : mem[rd_ptr[PTRWIDTH-1:0]];
    end

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_q, unf_q;
    always_ff @(posedge clk) begin
        if (flush) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q || (bus.wr_en && full_q);
            unf_q <= unf_q || (bus.rd_en && empty_q);
        end
    end
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif

    assign bus.data_out     = dout;
    assign bus.valid        = vld;
    assign bus.usedw        = usedw_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one standard-mode and one FWFT instance driven identically,
// checked every cycle against a queue model plus directed literal expectations.
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rstn, clr, we, re;
    logic [7:0] din;
    int         total = 0;
    int         bad = 0;
    bit         checking = 1'b0;

    // model state
    logic [7:0] q[$];
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         m_ovf, m_unf;

    always #5 clk = ~clk;

    sync_fifo_if #(.WIDTH(8), .PTRWIDTH(2)) bus0 ();
    sync_fifo_if #(.WIDTH(8), .PTRWIDTH(2)) bus1 ();

    assign bus0.clear = clr;  assign bus1.clear = clr;
    assign bus0.wr_en = we;   assign bus1.wr_en = we;
    assign bus0.data_in = din; assign bus1.data_in = din;
    assign bus0.rd_en = re;   assign bus1.rd_en = re;

    sync_fifo #(.WIDTH(8), .PTRWIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0))
        dut_std (.clk(clk), .rst_n(rstn), .bus(bus0));
    sync_fifo #(.WIDTH(8), .PTRWIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1))
        dut_fwft (.clk(clk), .rst_n(rstn), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the rules to the inputs seen at this edge.
    task automatic model_edge(input bit r, input bit c, input bit w, input logic [7:0] d, input bit rd);
        int n;
        n = q.size();
        if (!r) begin
            q.delete(); exp_data = 8'h00; exp_valid = 0; m_ovf = 0; m_unf = 0;
        end else if (c) begin
            q.delete(); exp_valid = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (w && n == 4) m_ovf = 1;
            if (rd && n == 0) m_unf = 1;
            exp_valid = rd && n > 0;
            if (exp_valid) begin
                exp_data = q[0];
                void'(q.pop_front());
            end
            if (w && n < 4) q.push_back(d);
        end
    endtask

    task automatic cycle(input bit r, input bit c, input bit w, input logic [7:0] d, input bit rd);
        @(negedge clk);
        rstn = r; clr = c; we = w; din = d; re = rd;
        @(posedge clk);
        model_edge(r, c, w, d, rd);
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("usedw_std", {29'd0, bus0.usedw}, q.size());
            check("usedw_fwft", {29'd0, bus1.usedw}, q.size());
            check("empty_std", {31'd0, bus0.empty}, {31'd0, q.size() == 0});
            check("full_std", {31'd0, bus0.full}, {31'd0, q.size() == 4});
            check("ae_std", {31'd0, bus0.almost_empty}, {31'd0, q.size() <= 1});
            check("af_std", {31'd0, bus0.almost_full}, {31'd0, q.size() >= 3});
            check("empty_fwft", {31'd0, bus1.empty}, {31'd0, q.size() == 0});
            check("full_fwft", {31'd0, bus1.full}, {31'd0, q.size() == 4});
            check("valid_std", {31'd0, bus0.valid}, {31'd0, exp_valid});
            check("data_std", {24'd0, bus0.data_out}, {24'd0, exp_data});
            check("valid_fwft", {31'd0, bus1.valid}, {31'd0, q.size() != 0});
            if (q.size() != 0)
                check("data_fwft", {24'd0, bus1.data_out}, {24'd0, q[0]});
`ifdef SYNC_FIFO_ERR_EN
            check("overflow", {31'd0, bus0.overflow}, {31'd0, m_ovf});
            check("underflow", {31'd0, bus0.underflow}, {31'd0, m_unf});
`endif
        end
    end

    initial begin
        rstn = 0; clr = 0; we = 0; re = 0; din = 8'h00;
        cycle(0, 0, 0, 8'h00, 0);
        checking = 1'b1;
        cycle(0, 0, 0, 8'h00, 0);
        check("rst_data", {24'd0, bus0.data_out}, 32'h0);
        check("rst_ae", {31'd0, bus0.almost_empty}, 32'h1);
        check("rst_af", {31'd0, bus0.almost_full}, 32'h0);

        // 1: fill and drain
        cycle(1, 0, 1, 8'hAA, 0);
        check("t1_usedw1", {29'd0, bus0.usedw}, 32'd1);
        cycle(1, 0, 1, 8'h11, 0);
        cycle(1, 0, 1, 8'h22, 0);
        check("t1_af", {31'd0, bus0.almost_full}, 32'h1);
        cycle(1, 0, 1, 8'h33, 0);
        check("t1_full", {31'd0, bus0.full}, 32'h1);
        cycle(1, 0, 0, 8'h00, 1);
        check("t1_rd0", {24'd0, bus0.data_out}, 32'hAA);
        cycle(1, 0, 0, 8'h00, 1);
        check("t1_rd1", {24'd0, bus0.data_out}, 32'h11);
        cycle(1, 0, 0, 8'h00, 1);
        cycle(1, 0, 0, 8'h00, 1);
        check("t1_rd3", {24'd0, bus0.data_out}, 32'h33);
        cycle(1, 0, 0, 8'h00, 0);
        check("t1_pulse", {31'd0, bus0.valid}, 32'h0);
        check("t1_empty", {31'd0, bus0.empty}, 32'h1);

        // 2: write into full fifo is rejected
        cycle(1, 0, 1, 8'hAA, 0);
        cycle(1, 0, 1, 8'h11, 0);
        cycle(1, 0, 1, 8'h22, 0);
        cycle(1, 0, 1, 8'h33, 0);
        cycle(1, 0, 1, 8'h44, 0);
        check("t2_usedw", {29'd0, bus0.usedw}, 32'd4);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'h00, 1);
        check("t2_last", {24'd0, bus0.data_out}, 32'h33);
        cycle(1, 0, 0, 8'h00, 0);
        check("t2_empty", {31'd0, bus0.empty}, 32'h1);
`ifdef SYNC_FIFO_ERR_EN
        check("t2_ovf_sticky", {31'd0, bus0.overflow}, 32'h1);
`endif

        // 3: concurrent read/write with wrap
        cycle(1, 0, 1, 8'h01, 0);
        cycle(1, 0, 1, 8'h02, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 1, 8'h03 + 8'(i), 1);
            check("t3_usedw", {29'd0, bus0.usedw}, 32'd2);
        end
        check("t3_data", {24'd0, bus0.data_out}, 32'h06);
        cycle(1, 0, 0, 8'h00, 1);
        cycle(1, 0, 0, 8'h00, 1);
        check("t3_tail", {24'd0, bus0.data_out}, 32'h08);

        // 4: show-ahead
        cycle(1, 0, 1, 8'h5A, 0);
        check("t4_valid", {31'd0, bus1.valid}, 32'h1);
        check("t4_data", {24'd0, bus1.data_out}, 32'h5A);
        cycle(1, 0, 0, 8'h00, 1);
        check("t4_empty", {31'd0, bus1.empty}, 32'h1);

        // 5: clear and reset beat a write
        cycle(1, 0, 1, 8'hC1, 0);
        cycle(1, 0, 1, 8'hC2, 0);
        cycle(1, 0, 1, 8'hC3, 0);
        cycle(1, 1, 1, 8'hEE, 0);
        check("t5_usedw", {29'd0, bus0.usedw}, 32'd0);
        check("t5_empty", {31'd0, bus0.empty}, 32'h1);
        check("t5_hold", {24'd0, bus0.data_out}, 32'h5A);
        cycle(1, 0, 1, 8'h77, 0);
        cycle(1, 0, 0, 8'h00, 1);
        check("t5_after", {24'd0, bus0.data_out}, 32'h77);
        cycle(1, 0, 1, 8'h99, 0);
        cycle(0, 0, 1, 8'h55, 0);
        check("t5_rst_data", {24'd0, bus0.data_out}, 32'h00);
        check("t5_rst_usedw", {29'd0, bus0.usedw}, 32'd0);

        // 6: read on empty
        cycle(1, 0, 0, 8'h00, 1);
        check("t6_valid", {31'd0, bus0.valid}, 32'h0);
        check("t6_usedw", {29'd0, bus0.usedw}, 32'd0);
`ifdef SYNC_FIFO_ERR_EN
        check("t6_unf", {31'd0, bus0.underflow}, 32'h1);
`endif
        cycle(1, 0, 0, 8'h00, 0);
        cycle(1, 0, 0, 8'h00, 0);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
